// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI channel typedefs and arbiter state encoding for the DDR read-port arbiter.
package axi_rd_arbiter_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        valid;
  } AXI_AW;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        valid;
  } AXI_W;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        valid;
  } AXI_AR;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        valid;
  } AXI_R;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_e;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// One AXI read port (AR + R channels); master drives the address and data-ready.
interface axi_rd_arbiter_if;
  import axi_rd_arbiter_pkg::*;

  AXI_AR ar;
  logic  arready;
  AXI_R  r;
  logic  rready;

  modport master (output ar, output rready, input arready, input r);
  modport slave  (input ar, input rready, output arready, output r);

endinterface

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: sole requester wins, ties go to i_prio.
module axi_rd_arbiter_rr_pick2 (
  input  logic [1:0] i_valid,
  input  logic       i_prio,
  output logic [1:0] o_grant,
  output logic       o_gnt_idx
);

  always_comb begin
    o_gnt_idx = 1'b0;
    unique case (i_valid)
      2'b01:   o_gnt_idx = 1'b0;
      2'b10:   o_gnt_idx = 1'b1;
      2'b11:   o_gnt_idx = i_prio;
      default: o_gnt_idx = 1'b0;
    endcase
    o_grant = (i_valid == 2'b00) ? 2'b00 : (o_gnt_idx ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter: round-robin grant held for one burst, one burst in flight,
// R beats steered back to the owner, optional sticky burst-length mismatch flag.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter bit RR_INIT   = 1'b0,
  parameter bit LEN_CHECK = 1'b1
) (
  input  logic             eth_rxck,
  input  logic             rst_rx,
  axi_rd_arbiter_if.slave  req0,
  axi_rd_arbiter_if.slave  req1,
  axi_rd_arbiter_if.master axi,
  output logic             owner_o,
  output logic             busy_o,
  output logic             err_o
);

  arb_state_e r_state, w_state_next;
  logic       r_prio;
  logic       r_owner;
  logic       r_err;
  AXI_AR      r_ar;
  logic [7:0] r_beat_cnt;

  logic [1:0] w_grant;
  logic       w_gnt_idx;
  AXI_AR      w_win_ar;
  logic       w_rready;
  logic       w_r_hs;
  logic       w_len_bad;

  axi_rd_arbiter_rr_pick2 u_pick (
    .i_valid   ({req1.ar.valid, req0.ar.valid}),
    .i_prio    (r_prio),
    .o_grant   (w_grant),
    .o_gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_win_ar       = w_gnt_idx ? req1.ar : req0.ar;
    w_win_ar.valid = 1'b1;
    w_rready       = (r_state == ARB_DATA) && (r_owner ? req1.rready : req0.rready);
    w_r_hs         = (r_state == ARB_DATA) && axi.r.valid && w_rready;
    // Early last, or the expected final beat arriving without last.
    w_len_bad      = axi.r.last ? (r_beat_cnt != r_ar.len) : (r_beat_cnt == r_ar.len);
  end

  always_ff @(posedge eth_rxck) begin
    if (rst_rx) r_state <= ARB_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (|w_grant)              w_state_next = ARB_ADDR;
      ARB_ADDR: if (axi.arready)           w_state_next = ARB_DATA;
      ARB_DATA: if (w_r_hs && axi.r.last)  w_state_next = ARB_IDLE;
      default:                             w_state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    req0.arready = (r_state == ARB_IDLE) && w_grant[0];
    req1.arready = (r_state == ARB_IDLE) && w_grant[1];
    axi.ar       = r_ar;
    axi.rready   = w_rready;
    req0.r       = '0;
    req1.r       = '0;
    if (r_state == ARB_DATA) begin
      if (r_owner) req1.r = axi.r;
      else         req0.r = axi.r;
    end
    owner_o = r_owner;
    busy_o  = (r_state != ARB_IDLE);
    err_o   = r_err;
  end

  always_ff @(posedge eth_rxck) begin
    if (rst_rx) begin
      r_prio     <= RR_INIT;
      r_owner    <= RR_INIT;
      r_ar       <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (|w_grant) begin
            r_ar    <= w_win_ar;
            r_owner <= w_gnt_idx;
          end
        end
        ARB_ADDR: begin
          if (axi.arready) begin
            r_ar.valid <= 1'b0;
            r_beat_cnt <= '0;
          end
        end
        ARB_DATA: begin
          if (w_r_hs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (axi.r.last) r_prio <= ~r_owner;
            if (LEN_CHECK && w_len_bad) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: memory responder model plus per-requester beat scoreboards.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic owner, busy, err;

  always #5 clk = ~clk;

  axi_rd_arbiter_if req0_if ();
  axi_rd_arbiter_if req1_if ();
  axi_rd_arbiter_if mem_if ();

  axi_rd_arbiter #(.RR_INIT(1'b0), .LEN_CHECK(1'b1)) dut (
    .eth_rxck (clk),
    .rst_rx   (rst),
    .req0     (req0_if),
    .req1     (req1_if),
    .axi      (mem_if),
    .owner_o  (owner),
    .busy_o   (busy),
    .err_o    (err)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [68:0] sb0[$];
  logic [68:0] sb1[$];
  logic        own_seq[$];
  int n_arr0 = 0, n_arr1 = 0, beats0 = 0, beats1 = 0, n_mem_hs = 0;
  int cyc_last = -1, cyc_ar = -1;
  bit watch = 0, clr0 = 0, clr1 = 0, tog1 = 0, no_r1 = 0, mirror = 0, err_pre = 0;
  logic [31:0] last_addr = '0;
  int cfg_ar_delay = 0, cfg_nbeats = 0;

  // Memory responder state.
  AXI_AR c_ar = '0;
  bit f_rst = 1'b1, f_arhs = 1'b0, f_rhs = 1'b0, f_arv = 1'b0, m_data = 1'b0;
  int m_dly = 0, m_beat = 0, m_nb = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [68:0] beat_word(input logic [3:0] id, input logic last,
                                            input logic [31:0] addr, input int b);
    return {id, last, addr, 24'h0, 8'(b)};
  endfunction

  // Memory side: outputs change on negedge, handshakes captured mid-low-phase.
  initial begin
    mem_if.arready = 1'b0;
    mem_if.r       = '0;
    forever begin
      @(negedge clk);
      if (f_rst) begin
        m_data = 1'b0;
        m_dly  = 0;
        mem_if.arready = 1'b0;
        mem_if.r       = '0;
      end else begin
        if (f_arhs) begin
          m_data = 1'b1;
          m_beat = 0;
          m_dly  = 0;
          mem_if.arready = 1'b0;
          m_nb = (cfg_nbeats == 0) ? int'(c_ar.len) + 1 : cfg_nbeats;
        end else if (!m_data && f_arv && !mem_if.arready) begin
          if (m_dly >= cfg_ar_delay) mem_if.arready = 1'b1;
          else m_dly++;
        end
        if (m_data) begin
          if (f_rhs && !f_arhs) m_beat++;
          if (m_beat >= m_nb) begin
            m_data   = 1'b0;
            mem_if.r = '0;
          end else begin
            mem_if.r.valid = 1'b1;
            mem_if.r.id    = c_ar.id;
            mem_if.r.data  = {c_ar.addr, 24'h0, 8'(m_beat)};
            mem_if.r.resp  = 2'b00;
            mem_if.r.last  = (m_beat == m_nb - 1);
          end
        end
      end
      #2;
      f_rst  = rst;
      f_arhs = mem_if.ar.valid && mem_if.arready;
      f_rhs  = mem_if.r.valid && mem_if.rready;
      f_arv  = mem_if.ar.valid;
      if (f_arhs) c_ar = mem_if.ar;
    end
  end

  task automatic tick();
    logic [68:0] e;
    #1;
    cyc++;
    if (req0_if.ar.valid && req0_if.arready) begin n_arr0++; clr0 = 1'b1; end
    if (req1_if.ar.valid && req1_if.arready) begin n_arr1++; clr1 = 1'b1; end
    if (mem_if.ar.valid && mem_if.arready) begin
      last_addr = mem_if.ar.addr;
      own_seq.push_back(owner);
    end
    if (watch && mem_if.ar.valid && cyc_ar < 0) cyc_ar = cyc;
    if (mem_if.r.valid && mem_if.rready) n_mem_hs++;
    if (no_r1) chk("t1_req1_rvalid", req1_if.r.valid, 1'b0);
    if (mirror && m_data) chk("t3_rready_mirror", mem_if.rready, req1_if.rready);
    if (req0_if.r.valid && req0_if.rready) begin
      beats0++;
      if (req0_if.r.last) cyc_last = cyc;
      if (err_pre && req0_if.r.last) chk("t4_err_before_last", err, 1'b0);
      n_vec++;
      assert (sb0.size() > 0) else begin
        n_bad++;
        $error("FAIL sb0_pop observed=extra_beat expected=no_beat");
      end
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        chk("r0_beat", {req0_if.r.id, req0_if.r.last, req0_if.r.data}, e);
      end
    end
    if (req1_if.r.valid && req1_if.rready) begin
      beats1++;
      n_vec++;
      assert (sb1.size() > 0) else begin
        n_bad++;
        $error("FAIL sb1_pop observed=extra_beat expected=no_beat");
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        chk("r1_beat", {req1_if.r.id, req1_if.r.last, req1_if.r.data}, e);
      end
    end
    @(negedge clk);
    if (clr0) begin req0_if.ar.valid = 1'b0; clr0 = 1'b0; end
    if (clr1) begin req1_if.ar.valid = 1'b0; clr1 = 1'b0; end
    if (tog1) req1_if.rready = ~req1_if.rready;
  endtask

  task automatic issue(input bit who, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] id, input int nb);
    AXI_AR a;
    a = '0;
    a.id = id; a.addr = addr; a.len = len; a.size = 3'd3; a.burst = 2'b01; a.valid = 1'b1;
    for (int b = 0; b < nb; b++) begin
      if (who) sb1.push_back(beat_word(id, b == nb - 1, addr, b));
      else     sb0.push_back(beat_word(id, b == nb - 1, addr, b));
    end
    if (who) req1_if.ar = a;
    else     req0_if.ar = a;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || req0_if.ar.valid || req1_if.ar.valid || sb0.size() != 0 ||
                sb1.size() != 0) && n < 300);
    chk({tag, "_timeout"}, n < 300, 1'b1);
  endtask

  task automatic wait_beats0(input int target, input string tag);
    int n;
    n = 0;
    while (beats0 < target && n < 100) begin tick(); n++; end
    chk({tag, "_timeout"}, n < 100, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb0.delete();
    sb1.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_owner"}, owner, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_axi_ar"}, mem_if.ar, '0);
    chk({tag, "_axi_rready"}, mem_if.rready, 1'b0);
    chk({tag, "_arready"}, {req1_if.arready, req0_if.arready}, 2'b00);
    chk({tag, "_rvalid"}, {req1_if.r.valid, req0_if.r.valid}, 2'b00);
  endtask

  initial begin
    int a0, b0, b1, h0;
    bit exp_seq[3];
    exp_seq = '{1'b0, 1'b1, 1'b0};
    req0_if.ar = '0; req0_if.rready = 1'b1;
    req1_if.ar = '0; req1_if.rready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Single request on requester 0.
    cfg_ar_delay = 2;
    no_r1 = 1'b1;
    a0 = n_arr0; b0 = beats0;
    issue(1'b0, 32'h1000_0040, 8'd3, 4'h5, 4);
    wait_idle("t1");
    no_r1 = 1'b0;
    chk("t1_arready_pulses", n_arr0 - a0, 1);
    chk("t1_axi_addr", last_addr, 32'h1000_0040);
    chk("t1_beats", beats0 - b0, 4);
    chk("t1_err", err, 1'b0);
    chk("t1_busy", busy, 1'b0);

    // Contention from reset: 0, then 1, then 0 again.
    cfg_ar_delay = 0;
    do_reset();
    own_seq.delete();
    issue(1'b0, 32'h2000_0000, 8'd1, 4'h1, 2);
    issue(1'b1, 32'h3000_0000, 8'd1, 4'h2, 2);
    tick();
    issue(1'b0, 32'h2000_1000, 8'd1, 4'h3, 2);
    wait_idle("t2");
    chk("t2_nbursts", own_seq.size(), 3);
    for (int i = 0; i < 3 && i < own_seq.size(); i++) chk("t2_owner_seq", own_seq[i], exp_seq[i]);

    // Backpressure on requester 1.
    req1_if.rready = 1'b0;
    tog1 = 1'b1;
    mirror = 1'b1;
    b1 = beats1; h0 = n_mem_hs;
    issue(1'b1, 32'h4000_0100, 8'd7, 4'h7, 8);
    wait_idle("t3");
    tog1 = 1'b0;
    mirror = 1'b0;
    req1_if.rready = 1'b1;
    chk("t3_beats", beats1 - b1, 8);
    chk("t3_mem_hs", n_mem_hs - h0, 8);
    chk("t3_err", err, 1'b0);

    // Early last: len=3 with last on beat 2.
    do_reset();
    err_pre = 1'b1;
    cfg_nbeats = 2;
    b0 = beats0;
    issue(1'b0, 32'h5000_0000, 8'd3, 4'h9, 2);
    wait_idle("t4a");
    err_pre = 1'b0;
    chk("t4a_err", err, 1'b1);
    chk("t4a_busy", busy, 1'b0);
    chk("t4a_beats", beats0 - b0, 2);

    // Late last: len=1 with last on beat 3.
    do_reset();
    chk("t4b_err_cleared", err, 1'b0);
    cfg_nbeats = 3;
    b0 = beats0;
    issue(1'b0, 32'h5100_0000, 8'd1, 4'hA, 3);
    wait_idle("t4b");
    chk("t4b_err", err, 1'b1);
    chk("t4b_beats", beats0 - b0, 3);
    cfg_nbeats = 0;

    // Reset during beat 2 of a burst.
    do_reset();
    b0 = beats0;
    issue(1'b0, 32'h6000_0000, 8'd3, 4'hB, 4);
    wait_beats0(b0 + 1, "t5_beat1");
    rst = 1'b1;
    tick();
    sb0.delete();
    chk_reset_outputs("t5_rst");
    rst = 1'b0;
    a0 = n_arr0; b0 = beats0;
    issue(1'b0, 32'h6100_0000, 8'd3, 4'hC, 4);
    wait_idle("t5_after");
    chk("t5_arready_pulses", n_arr0 - a0, 1);
    chk("t5_beats", beats0 - b0, 4);
    chk("t5_axi_addr", last_addr, 32'h6100_0000);

    // Back-to-back: req1 raised during req0's final beat.
    b0 = beats0;
    cyc_last = -1;
    cyc_ar = -1;
    issue(1'b0, 32'h7000_0000, 8'd1, 4'hD, 2);
    wait_beats0(b0 + 1, "t6_beat1");
    watch = 1'b1;
    issue(1'b1, 32'h7100_0000, 8'd0, 4'hE, 1);
    wait_idle("t6");
    watch = 1'b0;
    chk("t6_ar_latency", cyc_ar - cyc_last, 2);
    chk("t6_axi_addr", last_addr, 32'h7100_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
